// File: rtl/mdu_hilo_if.sv
// E-stage multiply/divide bus: controller launches ops and reads busy/HI/LO
// back through this bundle.
interface mdu_hilo_if;
  logic        start;
  logic [3:0]  HILO_Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HILO_out;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output start, HILO_Op, A, B,
    input  busy, HILO_out, HI, LO
  );

  modport slave (
    input  start, HILO_Op, A, B,
    output busy, HILO_out, HI, LO
  );
endinterface

// File: rtl/mdu_hilo.sv
// Fixed-latency multiply/divide unit with HI/LO registers. Results are
// computed at launch and held pending until the last busy cycle commits them.
module mdu_hilo #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  mdu_hilo_if.slave   bus
);

  localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   phi_q, phi_d, plo_q, plo_d;
  logic          pval_q, pval_d;

  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, dvd, dvs, q_u, r_u, q_s, r_s;
  logic        b_nz;

  assign prod_s = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
  assign prod_u = {32'b0, bus.A} * {32'b0, bus.B};

  // Signed divide runs on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
  always_comb begin
    a_mag = bus.A[31] ? (~bus.A + 32'd1) : bus.A;
    b_mag = bus.B[31] ? (~bus.B + 32'd1) : bus.B;
    dvd   = (bus.HILO_Op == OP_DIVU) ? bus.A : a_mag;
    dvs   = (bus.HILO_Op == OP_DIVU) ? bus.B : b_mag;
    b_nz  = (bus.B != '0);
    q_u   = '0;
    r_u   = '0;
    if (b_nz) begin
      q_u = dvd / dvs;
      r_u = dvd % dvs;
    end
    q_s = (bus.A[31] ^ bus.B[31]) ? (~q_u + 32'd1) : q_u;
    r_s = bus.A[31] ? (~r_u + 32'd1) : r_u;
  end

  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    phi_d  = phi_q;
    plo_d  = plo_q;
    pval_d = pval_q;
    if (busy_q) begin
      if (cnt_q == CW'(1)) begin
        if (pval_q) begin
          hi_d = phi_q;
          lo_d = plo_q;
        end
        cnt_d  = '0;
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end else if (bus.start && (bus.HILO_Op >= OP_MULT) && (bus.HILO_Op <= OP_DIVU)) begin
      busy_d = 1'b1;
      case (bus.HILO_Op)
        OP_MULT: begin
          {phi_d, plo_d} = prod_s;
          pval_d = 1'b1;
          cnt_d  = CW'(MULT_CYCLES);
        end
        OP_MULTU: begin
          {phi_d, plo_d} = prod_u;
          pval_d = 1'b1;
          cnt_d  = CW'(MULT_CYCLES);
        end
        OP_DIV: begin
          phi_d  = r_s;
          plo_d  = q_s;
          pval_d = b_nz;
          cnt_d  = CW'(DIV_CYCLES);
        end
        default: begin
          phi_d  = r_u;
          plo_d  = q_u;
          pval_d = b_nz;
          cnt_d  = CW'(DIV_CYCLES);
        end
      endcase
    end else if (bus.HILO_Op == OP_MTHI) begin
      hi_d = bus.A;
    end else if (bus.HILO_Op == OP_MTLO) begin
      lo_d = bus.A;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      phi_q  <= '0;
      plo_q  <= '0;
      pval_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      phi_q  <= phi_d;
      plo_q  <= plo_d;
      pval_q <= pval_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.HI       = hi_q;
  assign bus.LO       = lo_q;
  assign bus.HILO_out = (bus.HILO_Op == OP_MFHI) ? hi_q :
                        (bus.HILO_Op == OP_MFLO) ? lo_q : '0;

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed bench for mdu_hilo: vector table of launches plus corner sequences.
module tb_mdu_hilo;

  logic clk;
  logic reset;
  int unsigned total;
  int unsigned bad;

  mdu_hilo_if bus ();

  mdu_hilo #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int unsigned n;
  } vec_t;

  vec_t vecs [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic read_hilo(input string name, input logic [31:0] hi, input logic [31:0] lo);
    logic [3:0] save;
    save = bus.HILO_Op;
    bus.HILO_Op = 4'd7;
    #1;
    check({name, "_mfhi"}, bus.HILO_out, hi);
    bus.HILO_Op = 4'd8;
    #1;
    check({name, "_mflo"}, bus.HILO_out, lo);
    bus.HILO_Op = save;
    #1;
  endtask

  // Launch at the next edge, verify busy for exactly n cycles, then the result.
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int unsigned n,
                        input logic [31:0] hi, input logic [31:0] lo);
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    old_hi = bus.HI;
    old_lo = bus.LO;
    bus.start = 1'b1;
    bus.HILO_Op = op;
    bus.A = a;
    bus.B = b;
    tick();
    bus.start = 1'b0;
    bus.HILO_Op = 4'd0;
    for (int unsigned i = 0; i < n; i++) begin
      check($sformatf("%s_busy%0d", name, i), {31'b0, bus.busy}, 32'd1);
      if (i == n - 1) begin
        check({name, "_hi_pending"}, bus.HI, old_hi);
        check({name, "_lo_pending"}, bus.LO, old_lo);
      end
      tick();
    end
    check({name, "_busy_drop"}, {31'b0, bus.busy}, 32'd0);
    check({name, "_hi"}, bus.HI, hi);
    check({name, "_lo"}, bus.LO, lo);
  endtask

  initial begin
    total = 0;
    bad = 0;
    bus.start = 1'b0;
    bus.HILO_Op = 4'd0;
    bus.A = '0;
    bus.B = '0;

    vecs[0] = '{4'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1] = '{4'd2, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 5};
    vecs[2] = '{4'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3] = '{4'd4, 32'd7,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[4] = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[5] = '{4'd1, 32'd7,        32'd6,        32'h00000000, 32'h0000002A, 5};
    vecs[6] = '{4'd4, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10};
    vecs[7] = '{4'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[8] = '{4'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
    vecs[9] = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};

    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    check("rst_hi", bus.HI, 32'h0);
    check("rst_lo", bus.LO, 32'h0);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    read_hilo("rst", 32'h0, 32'h0);

    // Non-arith op with start must not launch.
    bus.start = 1'b1;
    bus.HILO_Op = 4'd7;
    tick();
    bus.start = 1'b0;
    bus.HILO_Op = 4'd0;
    check("start_mfhi_nobusy", {31'b0, bus.busy}, 32'd0);

    for (int i = 0; i < 10; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].n,
             vecs[i].hi, vecs[i].lo);
    read_hilo("after_vecs", 32'hFFFFFFFE, 32'h00000001);

    // mthi/mtlo then reads; op 0 and op 9 read zero.
    bus.HILO_Op = 4'd5;
    bus.A = 32'h1234;
    tick();
    bus.HILO_Op = 4'd6;
    bus.A = 32'h5678;
    tick();
    bus.HILO_Op = 4'd0;
    read_hilo("mtx", 32'h1234, 32'h5678);
    check("out_op0", bus.HILO_out, 32'h0);
    bus.HILO_Op = 4'd9;
    #1;
    check("out_op9", bus.HILO_out, 32'h0);
    bus.HILO_Op = 4'd0;

    // divu in flight; mtlo and a new mult launch are both ignored.
    bus.start = 1'b1;
    bus.HILO_Op = 4'd4;
    bus.A = 32'd100;
    bus.B = 32'd7;
    tick();
    bus.start = 1'b0;
    bus.HILO_Op = 4'd0;
    for (int unsigned i = 0; i < 10; i++) begin
      check($sformatf("intf_busy%0d", i), {31'b0, bus.busy}, 32'd1);
      if (i == 2) begin
        bus.HILO_Op = 4'd6;
        bus.A = 32'hAAAA;
      end else if (i == 4) begin
        bus.start = 1'b1;
        bus.HILO_Op = 4'd1;
        bus.A = 32'd7;
        bus.B = 32'd6;
      end else begin
        bus.start = 1'b0;
        bus.HILO_Op = 4'd0;
      end
      tick();
      if (i < 9) begin
        check($sformatf("intf_lo_hold%0d", i), bus.LO, 32'h5678);
      end
    end
    check("intf_busy_drop", {31'b0, bus.busy}, 32'd0);
    check("intf_hi", bus.HI, 32'h2);
    check("intf_lo", bus.LO, 32'hE);

    // Reset mid-mult aborts; nothing commits afterwards.
    bus.start = 1'b1;
    bus.HILO_Op = 4'd1;
    bus.A = 32'd7;
    bus.B = 32'd6;
    tick();
    bus.start = 1'b0;
    bus.HILO_Op = 4'd0;
    tick();
    check("abort_busy_before", {31'b0, bus.busy}, 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("abort_busy", {31'b0, bus.busy}, 32'd0);
    check("abort_hi", bus.HI, 32'h0);
    check("abort_lo", bus.LO, 32'h0);
    for (int i = 0; i < 8; i++) tick();
    check("abort_hi_late", bus.HI, 32'h0);
    check("abort_lo_late", bus.LO, 32'h0);
    check("abort_busy_late", {31'b0, bus.busy}, 32'd0);

    // Back-to-back: second launch on the cycle busy drops.
    run_op("b2b_first", 4'd1, 32'd7, 32'd6, 5, 32'h0, 32'h2A);
    run_op("b2b_second", 4'd2, 32'hFFFFFFFF, 32'd2, 5, 32'h1, 32'hFFFFFFFE);
    read_hilo("b2b", 32'h1, 32'hFFFFFFFE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Multiply/divide unit with HI/LO registers for the P6 pipeline, sitting in the E stage.
- It is the responder to the controller's `start` and `HILO_Op` outputs, and it returns `HILO_busy` to the stall logic.
- It runs mult/multu/div/divu as fixed-latency multi-cycle operations, services mthi/mtlo writes and provides mfhi/mflo read data.

Parameters:
- MULT_CYCLES, 5, busy duration in cycles for mult/multu (>=1).
- DIV_CYCLES, 10, busy duration in cycles for div/divu (>=1).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (reset==0 clears state on the next clk edge)
- start  input  1  E-stage mult/div launch strobe from controller
- HILO_Op  input  4  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; 9-15 treated as none
- A  input  32  rs operand (forwarded)
- B  input  32  rt operand (forwarded)
- busy  output  1  registered; high while an operation is in flight
- HILO_out  output  32  mfhi/mflo read data
- HI  output  32  committed HI register
- LO  output  32  committed LO register

Behaviour:
- Reset (reset==0 at an edge): HI=0, LO=0, busy=0, internal counter=0, pending results=0. Reset mid-operation aborts the operation and the result is never committed.
- Launch: at an edge with start=1, busy=0 and HILO_Op in {1,2,3,4}:
  - compute the result from A/B sampled at this edge into pending {phi, plo};
  - load counter with MULT_CYCLES or DIV_CYCLES; busy<=1.
- start=1 with HILO_Op not in 1-4: ignored. start=1 while busy=1: ignored, and the in-flight op is unaffected.
- Counting: while counter>1, it decrements each edge and busy stays 1. At the edge where counter==1: HI<=phi, LO<=plo, counter<=0, busy<=0.
- Timing: busy is high for exactly N cycles after the launch edge, and new HI/LO is visible in the cycle busy drops.
- Arithmetic:
  - mult: signed 32x32 to 64, {HI,LO}=product.
  - multu: unsigned 32x32 to 64.
  - div: LO=signed quotient truncated toward zero, HI=remainder with the sign of the dividend. 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - divu: unsigned quotient and remainder.
  - Divide by zero (B==0): full busy duration, then HI and LO keep their prior values (no commit).
- mthi/mtlo (op 5/6, start ignored): at the edge, HI<=A or LO<=A, only when busy=0. While busy=1 they are ignored; the stall unit prevents this case.
- Read: HILO_out is combinational, equal to HI when HILO_Op==7, LO when HILO_Op==8, else 0. It reflects committed registers only, never pending results.
- Commit vs write collision: cannot occur while busy=1 because writes are ignored. At the commit edge, the commit wins.
- HI and LO outputs are direct register outputs.
- Stall contract: the controller stalls D when a HILO_Op≠0 instruction is in D and (start_E | HILO_busy). This block guarantees busy rises on the edge after start.

Test Plan:
- Reset, then idle: HI=LO=0, busy=0, HILO_out=0 for ops 7 and 8.
- start, op=1, A=0xFFFFFFFE(-2), B=3 → busy=1 for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA, busy=0. Same operands with op=2 → HI=0x00000002, LO=0xFFFFFFFA.
- op=3, A=0xFFFFFFF9(-7), B=2 → busy for 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. op=4, A=7, B=0 → after 10 cycles HI/LO unchanged.
- Pre-load with mthi A=0x1234, mtlo A=0x5678 → mfhi reads 0x1234, mflo reads 0x5678. Launch divu, then issue mtlo A=0xAAAA and start(op=1) while busy → both ignored, and the divu result commits at cycle 10.
- Launch mult 7×6, then drive reset=0 at cycle 3 → busy=0 and HI=LO=0 next cycle, with no later commit.
- op=3, A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0. Back-to-back launch on the cycle busy drops is accepted with the correct new result.
